// File: rtl/wb_stream_reader_ctrl_if.sv
// rtl/wb_stream_reader_ctrl_if.sv - Wishbone write master and stream sink signal bundle
interface wb_stream_reader_ctrl_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
);
  logic [WB_AW-1:0]   wbm_adr_o;
  logic [WB_DW-1:0]   wbm_dat_o;
  logic [WB_DW/8-1:0] wbm_sel_o;
  logic               wbm_we_o;
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic [2:0]         wbm_cti_o;
  logic [1:0]         wbm_bte_o;
  logic               wbm_ack_i;
  logic               wbm_err_i;
  logic [WB_DW-1:0]   stream_s_data_i;
  logic               stream_s_valid_i;
  logic               stream_s_ready_o;

  // DMA engine side: drives the bus, sinks the stream
  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_cti_o, wbm_bte_o,
    input  wbm_ack_i, wbm_err_i,
    input  stream_s_data_i, stream_s_valid_i,
    output stream_s_ready_o
  );

  // Memory slave and stream source side
  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_cti_o, wbm_bte_o,
    output wbm_ack_i, wbm_err_i,
    output stream_s_data_i, stream_s_valid_i,
    input  stream_s_ready_o
  );
endinterface

// File: rtl/wb_stream_reader_ctrl.sv
// rtl/wb_stream_reader_ctrl.sv - stream-to-memory DMA writing Wishbone incrementing bursts
module wb_stream_reader_ctrl #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  wb_stream_reader_ctrl_if.master bus,
  input  logic                    enable,
  input  logic [WB_AW-1:0]        start_adr,
  input  logic [WB_AW-1:0]        buf_size,
  input  logic [WB_AW-1:0]        burst_size,
  output logic                    busy,
  output logic [WB_DW-1:0]        tx_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [WB_AW-1:0] DEPTH_A = WB_AW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;
  state_e state_q, state_d;

  logic [WB_DW-1:0]   fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WB_DW-1:0]   dat_q, dat_d;
  logic               full, push, pop;

  logic [WB_AW-1:0]   adr_q, adr_d, rem_q, rem_d;
  logic [CW-1:0]      blen_q, blen_d, beats_q, beats_d, len;
  logic [WB_DW-1:0]   tx_cnt_q, tx_cnt_d;
  logic               cyc_q, cyc_d;
  logic [2:0]         cti_q, cti_d;
  logic [WB_DW/8-1:0] sel_q, sel_d;
  logic [WB_AW-1:0]   cfg_words;
  logic               ack_beat, err_beat;

  assign full      = (count_q == DEPTH_C);
  assign push      = bus.stream_s_valid_i & ~full;
  // An error beat takes precedence over a simultaneous ack: nothing is popped or counted
  assign err_beat  = (state_q == S_BURST) & bus.wbm_err_i;
  assign ack_beat  = (state_q == S_BURST) & bus.wbm_ack_i & ~bus.wbm_err_i;
  assign pop       = ack_beat;
  assign cfg_words = buf_size >> 2;
  assign len       = (rem_q < WB_AW'(blen_q)) ? rem_q[CW-1:0] : blen_q;

  // FIFO pointers, occupancy and the next head word, which is registered onto wbm_dat_o
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    dat_d    = dat_q;
    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    // The word being written this cycle becomes the head when the FIFO drains to it
    if (push && (wr_ptr_q == rd_ptr_d)) dat_d = bus.stream_s_data_i;
    else if (count_d != '0)             dat_d = fifo_mem[rd_ptr_d];
  end

  // FIFO storage; contents are only read after being written, so it carries no reset
  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.stream_s_data_i;
  end

  // Transfer sequencing: latch config, wait for a full burst in the FIFO, then write it out
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    rem_d    = rem_q;
    blen_d   = blen_q;
    beats_d  = beats_q;
    tx_cnt_d = tx_cnt_q;
    cyc_d    = cyc_q;
    cti_d    = cti_q;
    sel_d    = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          adr_d    = start_adr;
          rem_d    = cfg_words;
          tx_cnt_d = '0;
          blen_d   = (burst_size > DEPTH_A) ? DEPTH_C : burst_size[CW-1:0];
          if ((cfg_words != '0) && (burst_size != '0)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q >= len) begin
          state_d = S_BURST;
          beats_d = len;
          cyc_d   = 1'b1;
          sel_d   = '1;
          cti_d   = (len == CW'(1)) ? 3'b111 : 3'b010;
        end
      end
      S_BURST: begin
        if (err_beat) begin
          cyc_d   = 1'b0;
          sel_d   = '0;
          cti_d   = 3'b000;
          state_d = S_IDLE;
        end else if (ack_beat) begin
          adr_d    = adr_q + WB_AW'(4);
          rem_d    = rem_q - WB_AW'(1);
          beats_d  = beats_q - CW'(1);
          tx_cnt_d = tx_cnt_q + WB_DW'(1);
          if (beats_q == CW'(1)) begin
            cyc_d   = 1'b0;
            sel_d   = '0;
            cti_d   = 3'b000;
            state_d = (rem_q == WB_AW'(1)) ? S_IDLE : S_WAIT;
          end else if (beats_q == CW'(2)) begin
            cti_d = 3'b111;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset empties the FIFO and drops the bus at once
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dat_q    <= '0;
      adr_q    <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      beats_q  <= '0;
      tx_cnt_q <= '0;
      cyc_q    <= 1'b0;
      cti_q    <= 3'b000;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dat_q    <= dat_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      beats_q  <= beats_d;
      tx_cnt_q <= tx_cnt_d;
      cyc_q    <= cyc_d;
      cti_q    <= cti_d;
      sel_q    <= sel_d;
    end
  end

  assign bus.wbm_adr_o        = adr_q;
  assign bus.wbm_dat_o        = dat_q;
  assign bus.wbm_sel_o        = sel_q;
  assign bus.wbm_we_o         = cyc_q;
  assign bus.wbm_cyc_o        = cyc_q;
  assign bus.wbm_stb_o        = cyc_q;
  assign bus.wbm_cti_o        = cti_q;
  assign bus.wbm_bte_o        = 2'b00;
  assign bus.stream_s_ready_o = ~full;
  assign busy                 = (state_q != S_IDLE);
  assign tx_cnt               = tx_cnt_q;
endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// tb/tb_wb_stream_reader_ctrl.sv - randomized bench with behavioural DMA model for wb_stream_reader_ctrl
module tb_wb_stream_reader_ctrl;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] start_adr, buf_size, burst_size;
  logic        busy;
  logic [31:0] tx_cnt;

  wb_stream_reader_ctrl_if #(.WB_AW(32), .WB_DW(32)) bus ();

  wb_stream_reader_ctrl #(.WB_AW(32), .WB_DW(32), .FIFO_AW(5)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n   (rst_n),
    .bus        (bus),
    .enable     (enable),
    .start_adr  (start_adr),
    .buf_size   (buf_size),
    .burst_size (burst_size),
    .busy       (busy),
    .tx_cnt     (tx_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model: FIFO contents as a queue, transfer as word counters
  logic [31:0] q[$];
  bit          m_busy, m_burst;
  logic [31:0] m_adr, m_rem, m_blen;
  int          m_done, m_left;
  int          src_seq, pushed, cyc_no;
  logic [31:0] memory [logic [31:0]];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic [2:0]  log_cti[$];
  int          last_ack_cyc, busy_fall_cyc, en_cyc, first_rise, busy_hi_cnt, err_cyc;
  bit          prev_busy, prev_cyc;

  // Stimulus knobs
  int          valid_pct, ack_pct, src_limit, err_beat;
  bit          ack_hold;
  logic [31:0] data_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc_no);
    end
  endtask

  // Compare DUT outputs against the model, then advance the model by the handshakes of the coming edge
  task automatic monitor();
    int len;
    cyc_no++;
    if (!rst_n) begin
      q.delete();
      m_busy = 0; m_burst = 0; m_done = 0; m_left = 0; m_adr = '0; m_rem = '0;
      src_seq = 0; pushed = 0; prev_busy = 0; prev_cyc = 0;
      chk("rst_cyc", 32'(bus.wbm_cyc_o), 0);
      chk("rst_stb", 32'(bus.wbm_stb_o), 0);
      chk("rst_we", 32'(bus.wbm_we_o), 0);
      chk("rst_sel", 32'(bus.wbm_sel_o), 0);
      chk("rst_adr", bus.wbm_adr_o, 0);
      chk("rst_dat", bus.wbm_dat_o, 0);
      chk("rst_cti", 32'(bus.wbm_cti_o), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tx_cnt", tx_cnt, 0);
      return;
    end
    chk("ready", 32'(bus.stream_s_ready_o), 32'(q.size() < 32));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("tx_cnt", tx_cnt, 32'(m_done));
    chk("cyc", 32'(bus.wbm_cyc_o), 32'(m_burst));
    chk("stb", 32'(bus.wbm_stb_o), 32'(m_burst));
    if (m_burst) begin
      chk("adr", bus.wbm_adr_o, m_adr);
      if (q.size() > 0) chk("dat", bus.wbm_dat_o, q[0]);
      chk("cti", 32'(bus.wbm_cti_o), (m_left == 1) ? 32'd7 : 32'd2);
      chk("sel", 32'(bus.wbm_sel_o), 32'hF);
      chk("we", 32'(bus.wbm_we_o), 1);
      chk("bte", 32'(bus.wbm_bte_o), 0);
    end
    if (busy) busy_hi_cnt++;
    if (prev_busy && !busy) busy_fall_cyc = cyc_no;
    if (!prev_cyc && bus.wbm_cyc_o && first_rise < 0) first_rise = cyc_no;
    prev_busy = busy;
    prev_cyc  = bus.wbm_cyc_o;

    if (m_burst) begin
      if (bus.wbm_err_i) begin
        m_burst = 0; m_busy = 0; err_cyc = cyc_no;
      end else if (bus.wbm_ack_i) begin
        memory[bus.wbm_adr_o] = bus.wbm_dat_o;
        log_adr.push_back(bus.wbm_adr_o);
        log_dat.push_back(bus.wbm_dat_o);
        log_cti.push_back(bus.wbm_cti_o);
        void'(q.pop_front());
        m_adr = m_adr + 4; m_rem = m_rem - 1; m_done++; m_left--;
        last_ack_cyc = cyc_no;
        if (m_left == 0) begin
          m_burst = 0;
          if (m_rem == 0) m_busy = 0;
        end
      end
    end else if (m_busy) begin
      len = (m_rem < m_blen) ? int'(m_rem) : int'(m_blen);
      if (q.size() >= len) begin m_burst = 1; m_left = len; end
    end else if (enable) begin
      m_adr  = start_adr;
      m_rem  = buf_size >> 2;
      m_done = 0;
      m_blen = (burst_size > 32) ? 32'd32 : burst_size;
      en_cyc = cyc_no;
      if (m_rem != 0 && burst_size != 0) m_busy = 1;
    end
    if (bus.stream_s_valid_i && bus.stream_s_ready_o) begin
      q.push_back(bus.stream_s_data_i);
      src_seq++;
      pushed++;
    end
  endtask

  // Stream source and Wishbone slave stimulus for the next edge
  task automatic drive();
    bus.stream_s_valid_i = (src_seq < src_limit) && (int'($urandom_range(0, 99)) < valid_pct);
    bus.stream_s_data_i  = data_base + 32'(src_seq);
    if (bus.wbm_cyc_o && rst_n) begin
      if (m_done == err_beat) begin
        bus.wbm_err_i = 1'b1; bus.wbm_ack_i = 1'b0;
      end else begin
        bus.wbm_err_i = 1'b0;
        bus.wbm_ack_i = !ack_hold && (int'($urandom_range(0, 99)) < ack_pct);
      end
    end else begin
      bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] s, input logic [31:0] b);
    start_adr = a; buf_size = s; burst_size = b; enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin step(); n++; end
    chk("done_timeout", 32'(busy), 0);
    step();
  endtask

  task automatic clear_logs();
    log_adr.delete(); log_dat.delete(); log_cti.delete(); memory.delete();
    first_rise = -1; busy_hi_cnt = 0;
  endtask

  initial begin
    int n, idx;
    rst_n = 1'b0; enable = 1'b0; start_adr = '0; buf_size = '0; burst_size = '0;
    bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
    bus.stream_s_valid_i = 1'b0; bus.stream_s_data_i = '0;
    valid_pct = 100; ack_pct = 100; src_limit = 0; err_beat = -1; ack_hold = 0; data_base = '0;
    cyc_no = 0; first_rise = -1;

    // Basic transfer: 16 words in bursts of 4
    src_limit = 16; data_base = 32'd0;
    do_reset();
    clear_logs();
    start(32'h1000, 32'd64, 32'd4);
    wait_done(500);
    chk("basic_beats", 32'(log_adr.size()), 16);
    if (log_adr.size() == 16) begin
      for (int i = 0; i < 4; i++) chk("basic_burst_adr", log_adr[4*i], 32'h1000 + 32'(16*i));
      for (int i = 0; i < 16; i++) chk("basic_cti", 32'(log_cti[i]), ((i % 4) == 3) ? 32'd7 : 32'd2);
    end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      a = 32'h1000 + 32'(4*i);
      chk("basic_mem", memory.exists(a) ? memory[a] : 32'hDEAD_BEEF, 32'(i));
    end
    chk("basic_tx_cnt", tx_cnt, 16);
    chk("basic_busy_fall", 32'(busy_fall_cyc), 32'(last_ack_cyc + 1));

    // Short final burst with the FIFO preloaded: cyc two cycles after enable
    src_limit = 6; data_base = 32'h0000_0100;
    do_reset();
    repeat (10) step();
    clear_logs();
    start(32'h2000, 32'd24, 32'd4);
    wait_done(500);
    chk("short_beats", 32'(log_adr.size()), 6);
    if (log_adr.size() == 6) begin
      chk("short_adr4", log_adr[4], 32'h2010);
      chk("short_cti4", 32'(log_cti[4]), 2);
      chk("short_cti5", 32'(log_cti[5]), 7);
    end
    chk("short_tx_cnt", tx_cnt, 6);
    chk("short_cyc_latency", 32'(first_rise - en_cyc), 2);

    // Backpressure: acks withheld, FIFO fills to exactly 32 words
    src_limit = 1000; data_base = 32'h0BAD_0000; ack_hold = 1;
    do_reset();
    clear_logs();
    start(32'h4000, 32'd400, 32'd4);
    repeat (40) step();
    chk("bp_accepted", 32'(pushed), 32);
    chk("bp_ready_low", 32'(bus.stream_s_ready_o), 0);
    ack_hold = 0;
    wait_done(2000);
    chk("bp_beats", 32'(log_dat.size()), 100);
    for (int i = 0; i < log_dat.size(); i++) chk("bp_order", log_dat[i], data_base + 32'(i));

    // Edge configurations
    src_limit = 1000; data_base = 32'h5000_0000;
    do_reset();
    clear_logs();
    start(32'h5000, 32'd64, 32'd0);
    repeat (10) step();
    start(32'h5000, 32'd3, 32'd4);
    repeat (10) step();
    chk("edge_busy_never", 32'(busy_hi_cnt), 0);
    chk("edge_no_beats", 32'(log_adr.size()), 0);
    chk("edge_tx_cnt", tx_cnt, 0);
    start(32'h6000, 32'd256, 32'd100);
    wait_done(1000);
    chk("big_beats", 32'(log_cti.size()), 64);
    idx = -1;
    for (int i = 0; i < log_cti.size(); i++) if (idx < 0 && log_cti[i] == 3'b111) idx = i;
    chk("big_burst_len", 32'(idx + 1), 32);

    // Error on beat 3 of burst 2, plus an enable while busy that must be ignored
    src_limit = 1000; data_base = 32'h3000_0000; err_beat = 6;
    do_reset();
    clear_logs();
    start(32'h3000, 32'd64, 32'd4);
    repeat (3) step();
    start(32'h9000, 32'd8, 32'd1);
    wait_done(500);
    err_beat = -1;
    chk("err_tx_cnt", tx_cnt, 6);
    chk("err_beats", 32'(log_adr.size()), 6);
    if (log_adr.size() == 6) chk("err_last_adr", log_adr[5], 32'h3014);
    chk("err_busy_fall", 32'(busy_fall_cyc), 32'(err_cyc + 1));
    chk("err_cyc_low", 32'(bus.wbm_cyc_o), 0);

    // Reset mid-burst, then a fresh transfer
    src_limit = 1000; data_base = 32'hA000_0000;
    do_reset();
    clear_logs();
    start(32'h7000, 32'd256, 32'd8);
    n = 0;
    while (!bus.wbm_cyc_o && n < 100) begin step(); n++; end
    chk("rmb_cyc_seen", 32'(bus.wbm_cyc_o), 1);
    step(); step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmb_async_cyc", 32'(bus.wbm_cyc_o), 0);
    chk("rmb_async_stb", 32'(bus.wbm_stb_o), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rmb_ready", 32'(bus.stream_s_ready_o), 1);
    clear_logs();
    start(32'h8000, 32'd32, 32'd4);
    chk("rmb_busy", 32'(busy), 1);
    chk("rmb_tx_cnt0", tx_cnt, 0);
    wait_done(500);
    chk("rmb_beats", 32'(log_adr.size()), 8);
    if (log_adr.size() > 0) begin
      chk("rmb_first_adr", log_adr[0], 32'h8000);
      chk("rmb_first_dat", log_dat[0], 32'hA000_0000);
    end
    chk("rmb_tx_cnt", tx_cnt, 8);

    // Randomized transfers back to back, leftover FIFO data carried between them
    for (int t = 0; t < 10; t++) begin
      logic [31:0] a;
      valid_pct = int'($urandom_range(30, 100));
      ack_pct   = int'($urandom_range(30, 100));
      src_limit = src_seq + 1000;
      data_base = $urandom;
      a = (t == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 32'h0000_FFFF)) << 2);
      start(a, 32'($urandom_range(0, 300)), 32'($urandom_range(0, 40)));
      wait_done(4000);
      repeat (int'($urandom_range(0, 5))) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
